// File: rtl/set_assoc_cache.sv
// Two-way set-associative cache with selectable write-back or write-through policy.
// A block of 2**BLK_BITS words moves one word per mem_ready handshake.
`timescale 1ns/1ps
module set_assoc_cache #(
    parameter int WORD_W     = 16,
    parameter int IDX_BITS   = 2,
    parameter int BLK_BITS   = 2,
    parameter int WRITE_BACK = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [WORD_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);
    localparam int SETS  = 1 << IDX_BITS;
    localparam int WORDS = 1 << BLK_BITS;
    localparam int TAG_W = WORD_W - IDX_BITS - BLK_BITS;
    localparam logic [BLK_BITS-1:0] LAST_WORD = BLK_BITS'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, WBACK, REFILL, WTWRITE} state_e;

    state_e               state_q, state_d;
    logic [SETS-1:0][1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [SETS-1:0]      lru_q, lru_d;
    logic [TAG_W-1:0]     tag_q  [SETS][2];
    logic [TAG_W-1:0]     tag_d  [SETS][2];
    logic [WORD_W-1:0]    data_q [SETS][2][WORDS];
    logic [WORD_W-1:0]    data_d [SETS][2][WORDS];
    logic [BLK_BITS-1:0]  cnt_q, cnt_d;
    logic                 victim_q, victim_d;
    logic                 missed_q, missed_d;
    logic [15:0]          hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    logic [BLK_BITS-1:0]  word_idx;
    logic [IDX_BITS-1:0]  set_idx;
    logic [TAG_W-1:0]     cpu_tag;
    logic                 hit0, hit1, hit, hit_way, victim_sel, alloc_req;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign word_idx   = cpu_addr[BLK_BITS-1:0];
    assign set_idx    = cpu_addr[IDX_BITS+BLK_BITS-1:BLK_BITS];
    assign cpu_tag    = cpu_addr[WORD_W-1:IDX_BITS+BLK_BITS];
    assign hit0       = valid_q[set_idx][0] && (tag_q[set_idx][0] == cpu_tag);
    assign hit1       = valid_q[set_idx][1] && (tag_q[set_idx][1] == cpu_tag);
    assign hit        = hit0 | hit1;
    assign hit_way    = hit1;
    assign victim_sel = !valid_q[set_idx][0] ? 1'b0 :
                        !valid_q[set_idx][1] ? 1'b1 : lru_q[set_idx];
    // Write-through writes never allocate, so only they bypass the refill path.
    assign alloc_req  = cpu_read || (cpu_write && (WRITE_BACK != 0));
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_comb begin
        // NOTE: every output and _d gets a default first so no path can infer a latch.
        state_d    = state_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        lru_d      = lru_q;
        tag_d      = tag_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        victim_d   = victim_q;
        missed_d   = missed_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        cpu_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (alloc_req) begin
                    if (hit) begin
                        cpu_ready = 1'b1;
                        lru_d[set_idx] = ~hit_way;
                        if (cpu_write) begin
                            data_d[set_idx][hit_way][word_idx] = cpu_wdata;
                            dirty_d[set_idx][hit_way] = 1'b1;
                        end
                    end else begin
                        missed_d   = 1'b1;
                        miss_cnt_d = sat_inc(miss_cnt_q);
                        victim_d   = victim_sel;
                        cnt_d      = '0;
                        state_d    = (valid_q[set_idx][victim_sel] && dirty_q[set_idx][victim_sel])
                                     ? WBACK : REFILL;
                    end
                end else if (cpu_write) begin
                    state_d = WTWRITE;
                    if (!hit) begin
                        missed_d   = 1'b1;
                        miss_cnt_d = sat_inc(miss_cnt_q);
                    end
                end
            end
            WBACK: begin
                mem_write = 1'b1;
                mem_addr  = {tag_q[set_idx][victim_q], set_idx, cnt_q};
                mem_wdata = data_q[set_idx][victim_q][cnt_q];
                if (mem_ready) begin
                    cnt_d = cnt_q + BLK_BITS'(1);
                    if (cnt_q == LAST_WORD) begin
                        dirty_d[set_idx][victim_q] = 1'b0;
                        cnt_d   = '0;
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                mem_read = 1'b1;
                mem_addr = {cpu_tag, set_idx, cnt_q};
                if (mem_ready) begin
                    data_d[set_idx][victim_q][cnt_q] = mem_rdata;
                    cnt_d = cnt_q + BLK_BITS'(1);
                    if (cnt_q == LAST_WORD) begin
                        tag_d[set_idx][victim_q]   = cpu_tag;
                        valid_d[set_idx][victim_q] = 1'b1;
                        dirty_d[set_idx][victim_q] = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            WTWRITE: begin
                mem_write = 1'b1;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                if (mem_ready) begin
                    cpu_ready = 1'b1;
                    state_d   = IDLE;
                    if (hit) begin
                        data_d[set_idx][hit_way][word_idx] = cpu_wdata;
                        lru_d[set_idx] = ~hit_way;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A request that ever missed completes as a hit but is not counted as one.
        if (cpu_ready) begin
            missed_d = 1'b0;
            if (!missed_q) hit_cnt_d = sat_inc(hit_cnt_q);
        end
        cpu_rdata = (cpu_ready && cpu_read) ? data_q[set_idx][hit_way][word_idx] : '0;
        if (!reset_n) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    // NOTE: tag and data arrays are not reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            lru_q      <= '0;
            cnt_q      <= '0;
            victim_q   <= 1'b0;
            missed_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            lru_q      <= lru_d;
            cnt_q      <= cnt_d;
            victim_q   <= victim_d;
            missed_q   <= missed_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: a write-back instance checked through a scoreboard and
// a write-through instance checked directly. Memory returns data equal to address.
`timescale 1ns/1ps
module tb_set_assoc_cache;
    typedef struct packed {
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
    } mem_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mready = 1'b1;

    logic        rd_w, wr_w, ready_w, mrd_w, mwr_w;
    logic [15:0] addr_w, wdata_w, rdata_w, maddr_w, mwdata_w, mrdata_w, hits_w, misses_w;
    logic        rd_t, wr_t, ready_t, mrd_t, mwr_t;
    logic [15:0] addr_t, wdata_t, rdata_t, maddr_t, mwdata_t, mrdata_t, hits_t, misses_t;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_rd [$];
    mem_t        exp_mem [$];
    int          wt_mw = 0;
    int          wt_mr = 0;
    logic [15:0] wt_last_a, wt_last_d;
    logic [15:0] mon_e;
    mem_t        mon_m;

    assign mrdata_w = maddr_w;
    assign mrdata_t = maddr_t;

    always #5 clk = ~clk;

    set_assoc_cache #(.WORD_W(16), .IDX_BITS(2), .BLK_BITS(2), .WRITE_BACK(1)) dut_wb (
        .clk(clk), .reset_n(reset_n),
        .cpu_read(rd_w), .cpu_write(wr_w), .cpu_addr(addr_w), .cpu_wdata(wdata_w),
        .cpu_rdata(rdata_w), .cpu_ready(ready_w),
        .mem_read(mrd_w), .mem_write(mwr_w), .mem_addr(maddr_w), .mem_wdata(mwdata_w),
        .mem_rdata(mrdata_w), .mem_ready(mready),
        .hit_count(hits_w), .miss_count(misses_w)
    );

    set_assoc_cache #(.WORD_W(16), .IDX_BITS(2), .BLK_BITS(2), .WRITE_BACK(0)) dut_wt (
        .clk(clk), .reset_n(reset_n),
        .cpu_read(rd_t), .cpu_write(wr_t), .cpu_addr(addr_t), .cpu_wdata(wdata_t),
        .cpu_rdata(rdata_t), .cpu_ready(ready_t),
        .mem_read(mrd_t), .mem_write(mwr_t), .mem_addr(maddr_t), .mem_wdata(mwdata_t),
        .mem_rdata(mrdata_t), .mem_ready(mready),
        .hit_count(hits_t), .miss_count(misses_t)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the write-back instance, sampled mid-cycle.
    always @(negedge clk) begin
        #1;
        if (ready_w && rd_w) begin
            if (exp_rd.size() == 0) begin
                checks++; failures++;
                $display("FAIL cpu_unexpected actual_rdata=%h addr=%h", rdata_w, addr_w);
            end else begin
                mon_e = exp_rd.pop_front();
                check("cpu_rdata", rdata_w, mon_e);
            end
        end
        if ((mrd_w || mwr_w) && mready) begin
            if (exp_mem.size() == 0) begin
                checks++; failures++;
                $display("FAIL mem_unexpected actual_write=%b addr=%h", mwr_w, maddr_w);
            end else begin
                mon_m = exp_mem.pop_front();
                check("mem_is_write", mwr_w, mon_m.w);
                check("mem_addr", maddr_w, mon_m.a);
                if (mon_m.w) check("mem_wdata", mwdata_w, mon_m.d);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (mwr_t && mready) begin
            wt_mw++;
            wt_last_a = maddr_t;
            wt_last_d = mwdata_t;
        end
        if (mrd_t && mready) wt_mr++;
    end

    task automatic req(input bit sel, input bit w, input logic [15:0] a, input logic [15:0] d,
                       output int lat, output logic [15:0] rdata_out);
        int n;
        n = 0;
        @(negedge clk);
        if (sel) begin rd_t = !w; wr_t = w; addr_t = a; wdata_t = d; end
        else     begin rd_w = !w; wr_w = w; addr_w = a; wdata_w = d; end
        #1;
        while (!(sel ? ready_t : ready_w) && n < 200) begin
            @(negedge clk); #1; n++;
        end
        rdata_out = sel ? rdata_t : rdata_w;
        if (!(sel ? ready_t : ready_w)) begin
            checks++; failures++;
            $display("FAIL timeout addr=%h cycles=%0d required_ready=1", a, n);
        end
        @(posedge clk); #1;
        if (sel) begin rd_t = 1'b0; wr_t = 1'b0; end
        else     begin rd_w = 1'b0; wr_w = 1'b0; end
        lat = n;
    endtask

    task automatic push_refill(input logic [15:0] base);
        for (int i = 0; i < 4; i++) exp_mem.push_back('{w: 1'b0, a: base + 16'(i), d: 16'h0});
    endtask

    task automatic push_wback(input logic [15:0] base, input logic [15:0] word0);
        for (int i = 0; i < 4; i++)
            exp_mem.push_back('{w: 1'b1, a: base + 16'(i), d: (i == 0) ? word0 : base + 16'(i)});
    endtask

    task automatic wb_op(input bit w, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp_data, input int exp_lat, input string nm);
        int          lat;
        logic [15:0] r;
        if (!w) exp_rd.push_back(exp_data);
        req(1'b0, w, a, d, lat, r);
        check({nm, "_latency"}, lat, exp_lat);
    endtask

    task automatic cnts(input string nm, input logic [15:0] h, input logic [15:0] m);
        check({nm, "_hits"}, hits_w, h);
        check({nm, "_misses"}, misses_w, m);
    endtask

    task automatic hold_hits(input int n);
        @(negedge clk);
        rd_w = 1'b1; wr_w = 1'b0; addr_w = 16'h0024;
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(16'h0024);
            @(negedge clk);
        end
        rd_w = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] r;
        reset_n = 1'b0;
        rd_w = 0; wr_w = 0; addr_w = 0; wdata_w = 0;
        rd_t = 0; wr_t = 0; addr_t = 0; wdata_t = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_ready", ready_w, 0);
        check("rst_strobes", {mrd_w, mwr_w, mrd_t, mwr_t}, 0);
        check("rst_rdata", rdata_w, 0);
        cnts("rst", 16'd0, 16'd0);
        check("rst_wt_counts", {hits_t, misses_t}, 0);
        reset_n = 1'b1;

        // Write-through: write miss goes straight to memory without allocation.
        req(1'b1, 1'b1, 16'h0020, 16'h1234, lat, r);
        check("wt_wmiss_latency", lat, 1);
        check("wt_wmiss_memwrites", wt_mw, 1);
        check("wt_wmiss_memreads", wt_mr, 0);
        check("wt_wmiss_addr", wt_last_a, 16'h0020);
        check("wt_wmiss_data", wt_last_d, 16'h1234);
        check("wt_wmiss_counts", {hits_t, misses_t}, {16'd0, 16'd1});
        req(1'b1, 1'b0, 16'h0020, 16'h0, lat, r);
        check("wt_read_after_write_latency", lat, 5);
        check("wt_read_rdata", r, 16'h0020);
        check("wt_read_memreads", wt_mr, 4);
        check("wt_read_misses", misses_t, 2);
        req(1'b1, 1'b1, 16'h0021, 16'hABCD, lat, r);
        check("wt_whit_latency", lat, 1);
        check("wt_whit_memwrites", wt_mw, 2);
        check("wt_whit_hits", hits_t, 1);
        req(1'b1, 1'b0, 16'h0021, 16'h0, lat, r);
        check("wt_rhit_latency", lat, 0);
        check("wt_rhit_rdata", r, 16'hABCD);
        check("wt_rhit_hits", hits_t, 2);

        // Write-back: cold miss then same-block hit.
        push_refill(16'h0010);
        wb_op(1'b0, 16'h0010, 16'h0, 16'h0010, 5, "cold_read");
        cnts("cold", 16'd0, 16'd1);
        wb_op(1'b0, 16'h0013, 16'h0, 16'h0013, 0, "hit_read");
        cnts("hit", 16'd1, 16'd1);

        // LRU replacement within set 0.
        push_refill(16'h0050);
        wb_op(1'b0, 16'h0050, 16'h0, 16'h0050, 5, "fill_way1");
        wb_op(1'b0, 16'h0010, 16'h0, 16'h0010, 0, "touch_0010");
        push_refill(16'h0090);
        wb_op(1'b0, 16'h0090, 16'h0, 16'h0090, 5, "evict_0050");
        wb_op(1'b0, 16'h0010, 16'h0, 16'h0010, 0, "0010_kept");
        push_refill(16'h0050);
        wb_op(1'b0, 16'h0050, 16'h0, 16'h0050, 5, "0050_gone");
        cnts("lru", 16'd3, 16'd4);

        // Dirty line is written back before the refill that evicts it.
        wb_op(1'b1, 16'h0010, 16'hBEEF, 16'h0, 0, "write_hit");
        wb_op(1'b0, 16'h0010, 16'h0, 16'hBEEF, 0, "read_written");
        wb_op(1'b0, 16'h0050, 16'h0, 16'h0050, 0, "touch_0050");
        push_wback(16'h0010, 16'hBEEF);
        push_refill(16'h0090);
        wb_op(1'b0, 16'h0090, 16'h0, 16'h0090, 9, "dirty_evict");
        cnts("wback", 16'd6, 16'd5);
        push_refill(16'h0010);
        wb_op(1'b0, 16'h0013, 16'h0, 16'h0013, 5, "reload_0013");
        wb_op(1'b1, 16'h0090, 16'h5555, 16'h0, 0, "dirty_0090");
        cnts("pre_reset", 16'd7, 16'd6);

        // Reset after two of four refill words aborts without writeback.
        exp_mem.push_back('{w: 1'b0, a: 16'h0024, d: 16'h0});
        exp_mem.push_back('{w: 1'b0, a: 16'h0025, d: 16'h0});
        @(negedge clk);
        rd_w = 1'b1; addr_w = 16'h0024;
        repeat (3) @(negedge clk);
        reset_n = 1'b0; rd_w = 1'b0;
        @(negedge clk); #1;
        check("abort_ready", ready_w, 0);
        check("abort_strobes", {mrd_w, mwr_w}, 0);
        check("abort_rdata", rdata_w, 0);
        cnts("abort", 16'd0, 16'd0);
        reset_n = 1'b1;
        push_refill(16'h0024);
        wb_op(1'b0, 16'h0024, 16'h0, 16'h0024, 5, "rearm_refill");
        push_refill(16'h0090);
        wb_op(1'b0, 16'h0090, 16'h0, 16'h0090, 5, "no_dirty_wback");
        cnts("post_reset", 16'd0, 16'd2);

        // Saturating hit counter.
        hold_hits(65534);
        cnts("sat_minus1", 16'hFFFE, 16'd2);
        hold_hits(1);
        cnts("sat_reach", 16'hFFFF, 16'd2);
        hold_hits(4);
        cnts("sat_hold", 16'hFFFF, 16'd2);

        repeat (2) @(negedge clk);
        check("exp_mem_drained", exp_mem.size(), 0);
        check("exp_rd_drained", exp_rd.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 Parameter WORD_W, default 16, data and address width in bits.
REQ-002 Parameter IDX_BITS, default 2, set-index width; sets = 2**IDX_BITS.
REQ-003 Parameter BLK_BITS, default 2, word-in-block width; block = 2**BLK_BITS words.
REQ-004 Parameter WRITE_BACK, default 1; 1 = write-back/write-allocate, 0 = write-through/no-allocate.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 reset_n  in  1  reset, synchronous, active-low.
REQ-007 cpu_read  in  1  CPU read request, held until cpu_ready.
REQ-008 cpu_write  in  1  CPU write request, held until cpu_ready; never asserted together with cpu_read.
REQ-009 cpu_addr  in  WORD_W  word address, held stable until cpu_ready.
REQ-010 cpu_wdata  in  WORD_W  write data.
REQ-011 cpu_rdata  out  WORD_W  read data, valid while cpu_ready and cpu_read.
REQ-012 cpu_ready  out  1  request completes this cycle.
REQ-013 mem_read / mem_write  out  1 each  memory request strobes, mutually exclusive.
REQ-014 mem_addr  out  WORD_W  memory word address.
REQ-015 mem_wdata  out  WORD_W  memory write data.
REQ-016 mem_rdata  in  WORD_W  memory read data, valid when mem_ready.
REQ-017 mem_ready  in  1  memory accepts/returns one word at this clock edge.
REQ-018 hit_count / miss_count  out  16 each  saturating performance counters.

Function
REQ-019 Address split SHALL be: word = addr[BLK_BITS-1:0], set = addr[IDX_BITS+BLK_BITS-1:BLK_BITS], tag = remaining MSBs.
REQ-020 Each set SHALL hold 2 ways (valid, dirty, tag, block) and one LRU bit naming the least-recently-used way.
REQ-021 Hit SHALL be combinational: valid and tag match in either way; never both ways matching.
REQ-022 FSM states SHALL be IDLE, WBACK, REFILL, WTWRITE; reset state IDLE.
REQ-023 IDLE read hit: cpu_ready=1 same cycle, cpu_rdata = hit word, no memory access.
REQ-024 IDLE write hit, WRITE_BACK=1: cpu_ready=1 same cycle; word written and dirty set at the edge.
REQ-025 Write, WRITE_BACK=0: go to WTWRITE; mem_write with cpu_addr/cpu_wdata held until mem_ready; cpu_ready=1 in the mem_ready cycle; on hit the cached word is updated at that edge; on miss no allocation.
REQ-026 Miss needing allocation (any read miss; write miss when WRITE_BACK=1): victim = invalid way0, else invalid way1, else LRU way; next state WBACK if victim valid and dirty, else REFILL.
REQ-027 WBACK SHALL assert mem_write for words 0..N-1 at {victim tag, set, i}, advancing i on each mem_ready; after word N-1 clear dirty, go to REFILL.
REQ-028 REFILL SHALL assert mem_read for words 0..N-1 at {cpu tag, set, i}, storing mem_rdata on each mem_ready; after word N-1 set tag, valid=1, dirty=0, go to IDLE, where the request completes as a hit.
REQ-029 Every completed CPU access to a resident way SHALL set that set's LRU bit to the other way.
REQ-030 miss_count SHALL increment once per request on leaving IDLE for WBACK/REFILL/WTWRITE-on-miss; hit_count SHALL increment on cpu_ready for requests that never missed; both saturate at 16'hFFFF.
REQ-031 cpu_ready SHALL be 0 in WBACK and REFILL; memory strobes 0 in IDLE.
REQ-032 Word counter SHALL be BLK_BITS wide and restart at 0 on each WBACK/REFILL entry.

Reset
REQ-033 reset_n=0 at an edge SHALL abort any transfer: state IDLE, all valid/dirty/LRU 0, counters 0, no writeback of dirty data.
REQ-034 During and after reset, until a new request: cpu_ready=0 unless a hit, mem_read=mem_write=0, cpu_rdata=0.

Verification (WORD_W=16, IDX_BITS=2, BLK_BITS=2, memory returns data=address, mem_ready every cycle)
REQ-035 Read 0x0010 cold -> 4 mem reads 0x0010..0x0013, then cpu_ready with cpu_rdata=0x0010; miss_count=1; read 0x0013 -> same-cycle ready, rdata 0x0013, hit_count=1.
REQ-036 Reads 0x0010, 0x0050, 0x0010, 0x0090 (all set 0) -> 0x0090 replaces the 0x0050 way; following read 0x0010 hits, read 0x0050 misses.
REQ-037 WRITE_BACK=1: write 0x0010=0xBEEF, read 0x0050, read 0x0090 -> 4 mem writes 0x0010..0x0013 (0x0010 carries 0xBEEF), then 4 mem reads 0x0090..0x0093.
REQ-038 WRITE_BACK=0: write 0x0020=0x1234 cold -> exactly one mem write, no mem read, miss_count=1; subsequent read 0x0020 misses.
REQ-039 Reset asserted after 2 of 4 REFILL words -> next cycle IDLE, strobes 0, counters 0; re-read of same address performs full 4-word refill.
REQ-040 Force hit_count to 0xFFFF via repeated hits -> stays 0xFFFF on further hits.
